mcu_scheduler: RTL and testbench
================================

# mcu_scheduler

Sequencing controller for the chroma supersampling stage of the JPEG decoder. It accepts a stream of decoded 8x8 blocks from the IDCT in 4:2:0 MCU order (Y0, Y1, Y2, Y3, Cb, Cr) and tags each block with its channel code before forwarding it to the supersampler. It also applies downstream backpressure and tracks MCU position across a frame. The supersampler then checks its own valid mask against the expected pattern. Block data bypasses this block; only control and handshake signals pass through it.

## Interface
Parameters:
- MCU_XW, 8, width of MCU column counter and configuration.
- MCU_YW, 8, width of MCU row counter and configuration.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame, honoured only in IDLE.
- cfg_mcu_cols  in  MCU_XW  frame width in MCUs, latched on accepted start.
- cfg_mcu_rows  in  MCU_YW  frame height in MCUs, latched on accepted start.
- in_valid  in  1  IDCT presents a block.
- in_ready  out  1  scheduler accepts the block this cycle.
- dn_ready  in  1  colour converter can absorb one supersampler output next cycle.
- ss_valid_in  out  1  drives supersampler valid_in; equals in_valid & in_ready.
- ss_ch  out  2  supersampler ch_in: 0=Y, 1=Cb, 2=Cr.
- ss_valid_out  in  4  supersampler valid_out, used for the sequence check.
- blk_idx  out  3  position 0..5 of the next block within the current MCU.
- mcu_x  out  MCU_XW  current MCU column.
- mcu_y  out  MCU_YW  current MCU row.
- busy  out  1  high when state is not IDLE.
- frame_done  out  1  one-cycle pulse after the final block is accepted.
- err_seq  out  1  sticky; a supersampler mask did not match the expected pattern.
- stall_cnt  out  16  only with MCU_SCHED_STALL_CNT_EN (see Configuration).

## Operation
- States:
  - IDLE: start goes to RUN if both dimensions are nonzero; otherwise it goes to DONE.
  - RUN: goes to DONE after the last block of the last MCU is accepted.
  - DONE: lasts one cycle, then goes to IDLE.
- in_ready = (state==RUN) & dn_ready. This is combinational; there is no other path from dn_ready.
- ss_ch is decoded from blk_idx:
  - 0–3 give 0.
  - 4 gives 1.
  - 5 gives 2.
- On each accepted block:
  - blk_idx increments.
  - At 5, blk_idx wraps to 0 and mcu_x increments.
  - When mcu_x reaches cfg_mcu_cols-1, mcu_x wraps to 0 and mcu_y increments.
- A start in IDLE clears mcu_x, mcu_y, blk_idx, err_seq and stall_cnt. A start outside IDLE is ignored.
- Sequence check:
  - On each accept, register exp_valid=1 and exp_mask. exp_mask is 4'b0001 for Y and 4'b1111 for Cb/Cr.
  - In the following cycle, if exp_valid is set and ss_valid_out != exp_mask, set err_seq.
  - With exp_valid low, ss_valid_out must be 0; otherwise set err_seq.
- err_seq does not stall the scheduler.
- Zero-dimension frame: no blocks are issued; frame_done still pulses.
- When rst_n is asserted, all state returns to its reset value immediately, including mid-frame; an in-flight block is discarded.

## Timing
- Reset values:
  - in_ready, ss_valid_in, busy, frame_done, err_seq and the internal exp_valid: 0.
  - blk_idx, mcu_x, mcu_y, stall_cnt: 0.
  - ss_ch: 0.
- start sampled at cycle S gives state RUN and busy=1 at S+1; in_ready can assert at S+1.
- An accept at cycle T updates counters at T+1. The supersampler output is checked at T+1, and err_seq reflects that check at T+2.
- If the last block is accepted at T:
  - state=DONE at T+1, with frame_done=1 and busy=1.
  - IDLE at T+2.
  - A new start can be accepted from T+2.
- Throughput is one block per cycle while in_valid and dn_ready are both high.

## Configuration
- MCU_SCHED_STALL_CNT_EN defined:
  - stall_cnt port exists.
  - It increments in RUN on cycles where in_valid=1 and dn_ready=0.
  - It saturates at 16'hFFFF and clears on an accepted start.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package jpeg_sched_pkg holds:
  - sched_state_t (IDLE, RUN, DONE).
  - CH_Y=0, CH_CB=1, CH_CR=2.
  - BLKS_PER_MCU=6.
  - MASK_Y=4'b0001, MASK_C=4'b1111.
- Sub-module mcu_pos_counter holds blk_idx, mcu_x and mcu_y, with wrap and carry logic. Its inputs are advance, clear and the latched cols.

## Test plan
- Reset: cols=2, rows=1, start, then continuous in_valid with dn_ready=1.
  - Expect 12 accepts with ss_ch sequence 0,0,0,0,1,2,0,0,0,0,1,2.
  - Expect mcu_x to go 0→1, frame_done exactly once at accept12+1, and busy low at accept12+2.
- Model supersampler returns 0001/1111 correctly: err_seq stays 0. Force 4'b0011 after a Cb accept: err_seq=1 two cycles later and stays set until the next start.
- dn_ready low for 5 cycles mid-MCU with in_valid high:
  - in_ready=0 and ss_valid_in=0 throughout.
  - blk_idx is held.
  - stall_cnt=5 when MCU_SCHED_STALL_CNT_EN is defined.
- cols=0, rows=3, start: no accepts, frame_done pulses at S+1, busy low at S+2.
- rst_n asserted after 3 accepts, then released: all outputs are at their reset values immediately. A new frame of cols=1, rows=1 completes after 6 accepts.
- start pulsed while in RUN: ignored, with counters and configuration unchanged.

Source files
------------

// File: rtl/jpeg_sched_pkg.sv
// Shared types and constants for the JPEG chroma supersampling scheduler.
// Consumed by mcu_scheduler and mcu_pos_counter.
package jpeg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam logic [1:0] CH_Y  = 2'd0;
    localparam logic [1:0] CH_CB = 2'd1;
    localparam logic [1:0] CH_CR = 2'd2;

    localparam int         BLKS_PER_MCU = 6;
    localparam logic [2:0] LAST_BLK     = 3'(BLKS_PER_MCU - 1);

    localparam logic [3:0] MASK_Y = 4'b0001;
    localparam logic [3:0] MASK_C = 4'b1111;

    // 4:2:0 MCU order: four luma blocks, then Cb, then Cr.
    function automatic logic [1:0] blk_to_ch(input logic [2:0] blk);
        if (blk < 3'd4) begin
            return CH_Y;
        end else if (blk == 3'd4) begin
            return CH_CB;
        end else begin
            return CH_CR;
        end
    endfunction

    function automatic logic [3:0] ch_to_mask(input logic [1:0] ch);
        return (ch == CH_Y) ? MASK_Y : MASK_C;
    endfunction

endpackage

// File: rtl/mcu_pos_counter.sv
// Block-within-MCU index and MCU column/row position, with wrap and carry.
// clear has priority over advance.
module mcu_pos_counter
    import jpeg_sched_pkg::*;
#(
    parameter int MCU_XW = 8,
    parameter int MCU_YW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [MCU_XW-1:0] cols,
    output logic [2:0]        blk_idx,
    output logic [MCU_XW-1:0] mcu_x,
    output logic [MCU_YW-1:0] mcu_y,
    output logic              blk_last,
    output logic              col_last
);

    localparam logic [MCU_XW-1:0] X_ONE = MCU_XW'(1);
    localparam logic [MCU_YW-1:0] Y_ONE = MCU_YW'(1);

    logic [2:0]        blk_reg, blk_next;
    logic [MCU_XW-1:0] x_reg, x_next;
    logic [MCU_YW-1:0] y_reg, y_next;

    assign blk_last = (blk_reg == LAST_BLK);
    assign col_last = (x_reg == cols - X_ONE);

    always_comb begin
        blk_next = blk_reg;
        x_next   = x_reg;
        y_next   = y_reg;
        if (clear) begin
            blk_next = '0;
            x_next   = '0;
            y_next   = '0;
        end else if (advance) begin
            if (blk_last) begin
                blk_next = '0;
                if (col_last) begin
                    x_next = '0;
                    y_next = y_reg + Y_ONE;
                end else begin
                    x_next = x_reg + X_ONE;
                end
            end else begin
                blk_next = blk_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_reg <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
        end else begin
            blk_reg <= blk_next;
            x_reg   <= x_next;
            y_reg   <= y_next;
        end
    end

    assign blk_idx = blk_reg;
    assign mcu_x   = x_reg;
    assign mcu_y   = y_reg;

endmodule

// File: rtl/mcu_scheduler.sv
// Tags 4:2:0 IDCT blocks with channel codes, gates them on downstream ready,
// and checks the supersampler's valid mask. Optional MCU_SCHED_STALL_CNT_EN adds stall_cnt.
module mcu_scheduler
    import jpeg_sched_pkg::*;
#(
    parameter int MCU_XW = 8,
    parameter int MCU_YW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MCU_XW-1:0] cfg_mcu_cols,
    input  logic [MCU_YW-1:0] cfg_mcu_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              dn_ready,
    output logic              ss_valid_in,
    output logic [1:0]        ss_ch,
    input  logic [3:0]        ss_valid_out,
    output logic [2:0]        blk_idx,
    output logic [MCU_XW-1:0] mcu_x,
    output logic [MCU_YW-1:0] mcu_y,
    output logic              busy,
    output logic              frame_done,
    output logic              err_seq
`ifdef MCU_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [MCU_YW-1:0] Y_ONE = MCU_YW'(1);

    sched_state_t      state_reg, state_next;
    logic [MCU_XW-1:0] cols_reg;
    logic [MCU_YW-1:0] rows_reg;
    logic              exp_valid_reg;
    logic [3:0]        exp_mask_reg;
    logic              err_reg;

    logic       start_acc;
    logic       accept;
    logic       last_accept;
    logic       blk_last;
    logic       col_last;
    logic       row_last;
    logic [3:0] mask_diff;
    logic       mismatch;

    assign start_acc   = start & (state_reg == IDLE);
    assign in_ready    = (state_reg == RUN) & dn_ready;
    assign accept      = in_valid & in_ready;
    assign ss_valid_in = accept;
    assign ss_ch       = blk_to_ch(blk_idx);
    assign busy        = (state_reg != IDLE);
    assign frame_done  = (state_reg == DONE);
    assign err_seq     = err_reg;

    assign row_last    = (mcu_y == rows_reg - Y_ONE);
    assign last_accept = accept & blk_last & col_last & row_last;

    mcu_pos_counter #(
        .MCU_XW (MCU_XW),
        .MCU_YW (MCU_YW)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_acc),
        .advance  (accept),
        .cols     (cols_reg),
        .blk_idx  (blk_idx),
        .mcu_x    (mcu_x),
        .mcu_y    (mcu_y),
        .blk_last (blk_last),
        .col_last (col_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ((cfg_mcu_cols != '0) && (cfg_mcu_rows != '0)) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cols_reg  <= '0;
            rows_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (start_acc) begin
                cols_reg <= cfg_mcu_cols;
                rows_reg <= cfg_mcu_rows;
            end
        end
    end

    // With no block in flight the supersampler must report an all-zero mask.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask_chk
        assign mask_diff[gi] = ss_valid_out[gi] ^ (exp_valid_reg & exp_mask_reg[gi]);
    end
    assign mismatch = |mask_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid_reg <= 1'b0;
            exp_mask_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            exp_valid_reg <= accept;
            exp_mask_reg  <= ch_to_mask(ss_ch);
            if (start_acc) begin
                err_reg <= 1'b0;
            end else if (mismatch) begin
                err_reg <= 1'b1;
            end
        end
    end

`ifdef MCU_SCHED_STALL_CNT_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_reg <= '0;
        end else if (start_acc) begin
            stall_reg <= '0;
        end else if ((state_reg == RUN) && in_valid && !dn_ready && (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_reg;
`endif

endmodule

// File: tb/tb_mcu_scheduler.sv
// Self-checking bench for mcu_scheduler: table-driven frame, hand-written corner
// sequences and randomized frames against a block-count reference model.
`timescale 1ns/1ps
module tb_mcu_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cfg_mcu_cols = 8'd0;
    logic [7:0] cfg_mcu_rows = 8'd0;
    logic       in_valid = 1'b0;
    logic       dn_ready = 1'b0;
    logic [3:0] ss_valid_out = 4'd0;
    logic       in_ready;
    logic       ss_valid_in;
    logic [1:0] ss_ch;
    logic [2:0] blk_idx;
    logic [7:0] mcu_x;
    logic [7:0] mcu_y;
    logic       busy;
    logic       frame_done;
    logic       err_seq;
`ifdef MCU_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    mcu_scheduler #(.MCU_XW(8), .MCU_YW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_mcu_cols (cfg_mcu_cols),
        .cfg_mcu_rows (cfg_mcu_rows),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dn_ready     (dn_ready),
        .ss_valid_in  (ss_valid_in),
        .ss_ch        (ss_ch),
        .ss_valid_out (ss_valid_out),
        .blk_idx      (blk_idx),
        .mcu_x        (mcu_x),
        .mcu_y        (mcu_y),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_seq      (err_seq)
`ifdef MCU_SCHED_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame progress expressed as a count of accepted blocks.
    int m_phase;      // 0 idle, 1 running, 2 done pulse
    int m_n;
    int m_cols;
    int m_rows;
    int m_stall;
    int m_prev_ch;
    bit m_err;
    bit m_prev_acc;
    int acc_count;

    bit         force_en;
    logic [3:0] force_val;

    typedef struct {
        bit st;
        bit iv;
        int e_rdy;
        int e_busy;
        int e_fd;
        int e_blk;
        int e_ch;
        int e_x;
    } vec_t;

    vec_t vecs[15];
    int   chs[12] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2};

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mask_of(input int ch);
        return (ch == 0) ? 1 : 15;
    endfunction

    function automatic int ch_of(input int blk);
        return (blk < 4) ? 0 : ((blk == 4) ? 1 : 2);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_cols = 0; m_rows = 0; m_stall = 0;
        m_err = 1'b0; m_prev_acc = 1'b0; m_prev_ch = 0;
    endtask

    // Drive one cycle's inputs and compare every output against the model.
    task automatic apply(input bit st, input int c, input int r, input bit iv, input bit dn);
        int blk, mcu, ex, ey;
        bit rdy;
        start = st; cfg_mcu_cols = 8'(c); cfg_mcu_rows = 8'(r);
        in_valid = iv; dn_ready = dn;
        ss_valid_out = force_en ? force_val : (m_prev_acc ? 4'(mask_of(m_prev_ch)) : 4'd0);
        #1;
        rdy = (m_phase == 1) && dn;
        blk = m_n % 6;
        mcu = m_n / 6;
        ex  = (m_cols == 0) ? 0 : mcu % m_cols;
        ey  = (m_cols == 0) ? 0 : mcu / m_cols;
        chk("in_ready", int'(in_ready), int'(rdy));
        chk("ss_valid_in", int'(ss_valid_in), int'(rdy && iv));
        chk("ss_ch", int'(ss_ch), ch_of(blk));
        chk("blk_idx", int'(blk_idx), blk);
        chk("mcu_x", int'(mcu_x), ex);
        chk("mcu_y", int'(mcu_y), ey);
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("frame_done", int'(frame_done), int'(m_phase == 2));
        chk("err_seq", int'(err_seq), int'(m_err));
`ifdef MCU_SCHED_STALL_CNT_EN
        chk("stall_cnt", int'(stall_cnt), m_stall);
`endif
    endtask

    task automatic advance();
        bit acc, mism, new_err;
        int cur_ch;
        acc     = (m_phase == 1) && dn_ready && in_valid;
        mism    = (ss_valid_out != (m_prev_acc ? 4'(mask_of(m_prev_ch)) : 4'd0));
        new_err = m_err | mism;
        cur_ch  = ch_of(m_n % 6);
        if (m_phase == 1 && in_valid && !dn_ready && m_stall < 65535) m_stall++;
        if (m_phase == 0 && start) begin
            m_n = 0; m_cols = int'(cfg_mcu_cols); m_rows = int'(cfg_mcu_rows);
            new_err = 1'b0; m_stall = 0;
            m_phase = (m_cols != 0 && m_rows != 0) ? 1 : 2;
        end else if (m_phase == 1 && acc) begin
            m_n++;
            if (m_n == 6 * m_cols * m_rows) m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end
        if (acc) acc_count++;
        m_err = new_err; m_prev_acc = acc; m_prev_ch = cur_ch;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit st, input int c, input int r, input bit iv, input bit dn);
        apply(st, c, r, iv, dn);
        advance();
    endtask

    task automatic run_to_idle(input int budget);
        int cyc;
        cyc = 0;
        while (m_phase != 0 && cyc < budget) begin
            step(1'b0, 0, 0, 1'b1, 1'b1);
            cyc++;
        end
        chk("frame_timeout", m_phase, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rc, rr;
        model_reset();
        force_en = 1'b0; force_val = 4'd0; acc_count = 0;

        vecs[0] = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
        for (int k = 1; k <= 12; k++) begin
            vecs[k] = '{1'b0, 1'b1, 1, 1, 0, (k - 1) % 6, chs[k - 1], (k - 1) / 6};
        end
        vecs[13] = '{1'b0, 1'b1, 0, 1, 1, 0, 0, 0};
        vecs[14] = '{1'b0, 1'b1, 0, 0, 0, 0, 0, 0};

        // Reset state, with dn_ready high to show in_ready is still gated.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        apply(1'b0, 0, 0, 1'b1, 1'b1);
        rst_n = 1'b1;
        advance();

        // Table: 2x1 frame with continuous input.
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].st, 2, 1, vecs[i].iv, 1'b1);
            chk("tbl_in_ready", int'(in_ready), vecs[i].e_rdy);
            chk("tbl_busy", int'(busy), vecs[i].e_busy);
            chk("tbl_frame_done", int'(frame_done), vecs[i].e_fd);
            chk("tbl_blk_idx", int'(blk_idx), vecs[i].e_blk);
            chk("tbl_ss_ch", int'(ss_ch), vecs[i].e_ch);
            chk("tbl_mcu_x", int'(mcu_x), vecs[i].e_x);
            advance();
        end

        // Bad mask after a Cb accept.
        step(1'b1, 1, 1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1, 1, 1'b1, 1'b1);
        force_en = 1'b1; force_val = 4'b0011;
        apply(1'b0, 1, 1, 1'b1, 1'b1);
        chk("err_not_yet", int'(err_seq), 0);
        advance();
        force_en = 1'b0;
        apply(1'b0, 1, 1, 1'b0, 1'b1);
        chk("err_set", int'(err_seq), 1);
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 0, 0, 1'b0, 1'b1);
            chk("err_sticky", int'(err_seq), 1);
            advance();
        end
        step(1'b1, 1, 1, 1'b0, 1'b1);
        apply(1'b0, 1, 1, 1'b1, 1'b1);
        chk("err_cleared", int'(err_seq), 0);
        advance();
        run_to_idle(50);

        // Downstream stall mid-MCU.
        step(1'b1, 1, 2, 1'b0, 1'b1);
        step(1'b0, 1, 2, 1'b1, 1'b1);
        step(1'b0, 1, 2, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1, 2, 1'b1, 1'b0);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_ss_valid_in", int'(ss_valid_in), 0);
            chk("stall_blk_held", int'(blk_idx), 2);
            advance();
        end
`ifdef MCU_SCHED_STALL_CNT_EN
        apply(1'b0, 1, 2, 1'b1, 1'b1);
        chk("stall_cnt_5", int'(stall_cnt), 5);
        advance();
`endif
        run_to_idle(50);

        // Zero-width frame.
        step(1'b1, 0, 3, 1'b0, 1'b1);
        apply(1'b0, 0, 0, 1'b1, 1'b1);
        chk("zero_frame_done", int'(frame_done), 1);
        chk("zero_busy", int'(busy), 1);
        chk("zero_in_ready", int'(in_ready), 0);
        advance();
        apply(1'b0, 0, 0, 1'b1, 1'b1);
        chk("zero_idle_busy", int'(busy), 0);
        chk("zero_idle_fd", int'(frame_done), 0);
        advance();

        // Asynchronous reset mid-frame.
        step(1'b1, 2, 2, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 2, 2, 1'b1, 1'b1);
        in_valid = 1'b1; dn_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_ss_valid_in", int'(ss_valid_in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_blk_idx", int'(blk_idx), 0);
        chk("rst_mcu_x", int'(mcu_x), 0);
        chk("rst_mcu_y", int'(mcu_y), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_err_seq", int'(err_seq), 0);
        model_reset();
        ss_valid_out = 4'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1, 1, 1'b0, 1'b1);
        base = acc_count;
        for (int k = 0; k < 6; k++) step(1'b0, 1, 1, 1'b1, 1'b1);
        apply(1'b0, 1, 1, 1'b1, 1'b1);
        chk("rst_new_frame_done", int'(frame_done), 1);
        chk("rst_new_frame_accepts", acc_count - base, 6);
        advance();
        run_to_idle(10);

        // start during RUN must not disturb the frame in flight.
        step(1'b1, 2, 1, 1'b0, 1'b1);
        base = acc_count;
        for (int k = 0; k < 3; k++) step(1'b0, 2, 1, 1'b1, 1'b1);
        step(1'b1, 3, 3, 1'b1, 1'b1);
        run_to_idle(50);
        chk("ignored_start_accepts", acc_count - base, 12);

        // Randomized frames with random handshakes and occasional bad masks.
        for (int f = 0; f < 20; f++) begin
            rc = $urandom_range(0, 3);
            rr = $urandom_range(0, 3);
            step(1'b1, rc, rr, 1'b0, 1'($urandom_range(0, 1)));
            for (int cyc = 0; cyc < 400 && m_phase != 0; cyc++) begin
                force_en  = ($urandom_range(0, 29) == 0);
                force_val = 4'($urandom);
                step(($urandom_range(0, 15) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            end
            force_en = 1'b0;
            chk("rand_frame_end", m_phase, 0);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
